// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared core types: CDB broadcast record and CDB requester indices
package rv32i_types;

  localparam int CDB_NUM_REQ  = 4;
  localparam int CDB_PR_BITS  = 6;
  localparam int CDB_ROB_BITS = 5;

  // Requester slots on the common data bus
  localparam int CDB_REQ_BR  = 0;
  localparam int CDB_REQ_ALU = 1;
  localparam int CDB_REQ_MUL = 2;
  localparam int CDB_REQ_LSU = 3;

  typedef struct packed {
    logic                    valid;
    logic [CDB_PR_BITS-1:0]  pd;
    logic [4:0]              rd_s;
    logic [CDB_ROB_BITS-1:0] rob_idx;
    logic [31:0]             data;
    logic                    regf_we;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority grant starting at a pointer
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  // Walk ptr, ptr+1, ... modulo N and take the first requester found
  always_comb begin
    logic [W:0]   sum;
    logic [W-1:0] pos;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      pos = sum[W-1:0];
      if (!any && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter, optional perf counters under CDB_PERF_EN
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ  = CDB_NUM_REQ,
  parameter int PR_BITS  = CDB_PR_BITS,
  parameter int ROB_BITS = CDB_ROB_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*PR_BITS-1:0]    req_pd,
  input  logic [NUM_REQ*5-1:0]          req_rd_s,
  input  logic [NUM_REQ*ROB_BITS-1:0]   req_rob_idx,
  input  logic [NUM_REQ*32-1:0]         req_data,
  input  logic [NUM_REQ-1:0]            req_regf_we,
  output logic                          cdb_valid,
  output logic [PR_BITS-1:0]            cdb_pd,
  output logic [4:0]                    cdb_rd_s,
  output logic [ROB_BITS-1:0]           cdb_rob_idx,
  output logic [31:0]                   cdb_data,
  output logic                          cdb_regf_we,
  output logic [$clog2(NUM_REQ)-1:0]    cdb_src
`ifdef CDB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]         perf_stall_cnt,
  output logic [31:0]                   perf_bcast_cnt
`endif
);

  localparam int SRC_BITS = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  req_eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [SRC_BITS-1:0] grant_idx;
  logic                grant_any;
  logic [SRC_BITS-1:0] rr_ptr;
  logic [SRC_BITS-1:0] rr_ptr_next;
  cdb_t                cdb_q;
  cdb_t                cdb_next;
  logic [SRC_BITS-1:0] src_q;

  logic [PR_BITS-1:0]  pd_arr   [NUM_REQ];
  logic [4:0]          rd_arr   [NUM_REQ];
  logic [ROB_BITS-1:0] rob_arr  [NUM_REQ];
  logic [31:0]         data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign pd_arr[g]   = req_pd[g*PR_BITS +: PR_BITS];
    assign rd_arr[g]   = req_rd_s[g*5 +: 5];
    assign rob_arr[g]  = req_rob_idx[g*ROB_BITS +: ROB_BITS];
    assign data_arr[g] = req_data[g*32 +: 32];
  end

  // Reset and flush both suppress any grant in the current cycle
  assign req_eligible = req_valid & {NUM_REQ{~(rst | flush)}};

  rr_arbiter #(
    .N (NUM_REQ),
    .W (SRC_BITS)
  ) u_rr (
    .req   (req_eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_ready = grant;

  // Next pointer is one past the winner, wrapping at the last requester
  assign rr_ptr_next = (grant_idx == SRC_BITS'(NUM_REQ-1)) ? '0 : grant_idx + SRC_BITS'(1);

  // Select the winner's payload; an x0 destination never writes the register file
  always_comb begin
    cdb_next         = '0;
    cdb_next.valid   = 1'b1;
    cdb_next.pd      = pd_arr[grant_idx];
    cdb_next.rd_s    = rd_arr[grant_idx];
    cdb_next.rob_idx = rob_arr[grant_idx];
    cdb_next.data    = data_arr[grant_idx];
    cdb_next.regf_we = req_regf_we[grant_idx] & (rd_arr[grant_idx] != 5'd0);
  end

  // Broadcast register and round-robin pointer; idle cycles keep the payload
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q  <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
    end else if (grant_any) begin
      cdb_q  <= cdb_next;
      src_q  <= grant_idx;
      rr_ptr <= rr_ptr_next;
    end else begin
      cdb_q.valid <= 1'b0;
    end
  end

  assign cdb_valid   = cdb_q.valid;
  assign cdb_pd      = cdb_q.pd;
  assign cdb_rd_s    = cdb_q.rd_s;
  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_data    = cdb_q.data;
  assign cdb_regf_we = cdb_q.regf_we;
  assign cdb_src     = src_q;

`ifdef CDB_PERF_EN
  logic [31:0] stall_q [NUM_REQ];
  logic [31:0] bcast_q;

  // Saturating per-requester stall counters and broadcast counter; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stall_q[i] <= '0;
      end
      bcast_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && (stall_q[i] != 32'hFFFF_FFFF)) begin
          stall_q[i] <= stall_q[i] + 32'd1;
        end
      end
      if (cdb_q.valid && (bcast_q != 32'hFFFF_FFFF)) begin
        bcast_q <= bcast_q + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_stall_cnt[g*32 +: 32] = stall_q[g];
  end
  assign perf_bcast_cnt = bcast_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter, perf checks under CDB_PERF_EN
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N  = 4;
  localparam int PB = 6;
  localparam int RB = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*PB-1:0] req_pd;
  logic [N*5-1:0]  req_rd_s;
  logic [N*RB-1:0] req_rob_idx;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_regf_we;
  logic            cdb_valid;
  logic [PB-1:0]   cdb_pd;
  logic [4:0]      cdb_rd_s;
  logic [RB-1:0]   cdb_rob_idx;
  logic [31:0]     cdb_data;
  logic            cdb_regf_we;
  logic [1:0]      cdb_src;
`ifdef CDB_PERF_EN
  logic [N*32-1:0] perf_stall_cnt;
  logic [31:0]     perf_bcast_cnt;
`endif

  cdb_arbiter #(.NUM_REQ(N), .PR_BITS(PB), .ROB_BITS(RB)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pd      (req_pd),
    .req_rd_s    (req_rd_s),
    .req_rob_idx (req_rob_idx),
    .req_data    (req_data),
    .req_regf_we (req_regf_we),
    .cdb_valid   (cdb_valid),
    .cdb_pd      (cdb_pd),
    .cdb_rd_s    (cdb_rd_s),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_data    (cdb_data),
    .cdb_regf_we (cdb_regf_we),
    .cdb_src     (cdb_src)
`ifdef CDB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bcast_cnt (perf_bcast_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PB-1:0] pd_f(int i, int v);
    return PB'((i*13 + v) & 63);
  endfunction
  function automatic logic [RB-1:0] rob_f(int i, int v);
    return RB'((i*7 + v) & 31);
  endfunction
  function automatic logic [31:0] data_f(int i, int v);
    return 32'(32'h1000_0000 * (i+1) + v);
  endfunction
  function automatic logic [4:0] rd_f(int i, int v, logic z);
    return z ? 5'd0 : 5'(i + 1 + (v & 3));
  endfunction

  task automatic set_payload(input int v, input logic z);
    for (int i = 0; i < N; i++) begin
      req_pd[i*PB +: PB]      = pd_f(i, v);
      req_rob_idx[i*RB +: RB] = rob_f(i, v);
      req_data[i*32 +: 32]    = data_f(i, v);
      req_rd_s[i*5 +: 5]      = rd_f(i, v, z);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       flush;
    logic [3:0] valid;
    logic [3:0] we;
    logic       zrd;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_src;
    logic [1:0] exp_ptr;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic [3:0] vld, logic [3:0] we, logic z,
                              logic [3:0] rdy, logic ev, logic [1:0] es, logic [1:0] ep);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = vld; t.we = we; t.zrd = z;
    t.exp_ready = rdy; t.exp_valid = ev; t.exp_src = es; t.exp_ptr = ep;
    return t;
  endfunction

  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [PB-1:0] e_pd;
    logic [4:0]    e_rd;
    logic [RB-1:0] e_rob;
    logic [31:0]   e_data;
    logic          e_we;
    logic [1:0]    e_src;
    int            s;

    tbl[0]  = mk(1, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 1);
    tbl[2]  = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 2);
    tbl[3]  = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 2, 3);
    tbl[4]  = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 3, 0);
    tbl[5]  = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 1);
    tbl[6]  = mk(0, 0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 0, 1);
    tbl[7]  = mk(0, 0, 4'b0100, 4'b1111, 0, 4'b0100, 1, 2, 3);
    tbl[8]  = mk(0, 0, 4'b0101, 4'b1111, 0, 4'b0001, 1, 0, 1);
    tbl[9]  = mk(0, 0, 4'b0100, 4'b1111, 0, 4'b0100, 1, 2, 3);
    tbl[10] = mk(0, 0, 4'b1000, 4'b1111, 1, 4'b1000, 1, 3, 0);
    tbl[11] = mk(0, 0, 4'b1000, 4'b0111, 0, 4'b1000, 1, 3, 0);
    tbl[12] = mk(0, 0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 2);
    tbl[13] = mk(0, 1, 4'b0110, 4'b1111, 0, 4'b0000, 0, 0, 2);
    tbl[14] = mk(0, 0, 4'b0110, 4'b1111, 0, 4'b0100, 1, 2, 3);
    tbl[15] = mk(0, 0, 4'b0010, 4'b1111, 0, 4'b0010, 1, 1, 2);
    tbl[16] = mk(1, 1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0);
    tbl[17] = mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 1);

    rst = 1'b1; flush = 1'b0; req_valid = '0; req_regf_we = '0;
    set_payload(0, 1'b0);

    // Reset state, and no grant while reset is high
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b0010;
    #1 chk("ready_in_rst", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("rst_valid", 32'(cdb_valid), 32'h0);
    chk("rst_pd", 32'(cdb_pd), 32'h0);
    chk("rst_data", cdb_data, 32'h0);
    chk("rst_src", 32'(cdb_src), 32'h0);
    chk("rst_ptr", 32'(dut.rr_ptr), 32'h0);

    // Single ALU request, then idle
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0010; req_regf_we = 4'b0010;
    req_pd[CDB_REQ_ALU*PB +: PB] = 6'd9;
    req_data[CDB_REQ_ALU*32 +: 32] = 32'hDEAD_BEEF;
    req_rd_s[CDB_REQ_ALU*5 +: 5] = 5'd5;
    #1 chk("single_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    chk("single_valid", 32'(cdb_valid), 32'h1);
    chk("single_pd", 32'(cdb_pd), 32'd9);
    chk("single_data", cdb_data, 32'hDEAD_BEEF);
    chk("single_rd", 32'(cdb_rd_s), 32'd5);
    chk("single_we", 32'(cdb_regf_we), 32'h1);
    chk("single_src", 32'(cdb_src), 32'd1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk("idle_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("idle_valid", 32'(cdb_valid), 32'h0);
    chk("idle_pd_hold", 32'(cdb_pd), 32'd9);
    chk("idle_ptr", 32'(dut.rr_ptr), 32'd2);

    e_pd = '0; e_rd = '0; e_rob = '0; e_data = '0; e_we = 1'b0; e_src = '0;
    for (int v = 0; v < 18; v++) begin
      @(negedge clk);
      rst = tbl[v].rst; flush = tbl[v].flush;
      req_valid = tbl[v].valid; req_regf_we = tbl[v].we;
      set_payload(v, tbl[v].zrd);
      #1 chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      @(posedge clk); #1;
      if (tbl[v].rst) begin
        e_pd = '0; e_rd = '0; e_rob = '0; e_data = '0; e_we = 1'b0; e_src = '0;
      end else if (tbl[v].exp_valid) begin
        s      = int'(tbl[v].exp_src);
        e_src  = tbl[v].exp_src;
        e_pd   = pd_f(s, v);
        e_rd   = rd_f(s, v, tbl[v].zrd);
        e_rob  = rob_f(s, v);
        e_data = data_f(s, v);
        e_we   = tbl[v].we[s] & ~tbl[v].zrd;
      end
      chk($sformatf("v%0d_valid", v), 32'(cdb_valid), 32'(tbl[v].exp_valid));
      chk($sformatf("v%0d_src", v), 32'(cdb_src), 32'(e_src));
      chk($sformatf("v%0d_pd", v), 32'(cdb_pd), 32'(e_pd));
      chk($sformatf("v%0d_rd", v), 32'(cdb_rd_s), 32'(e_rd));
      chk($sformatf("v%0d_rob", v), 32'(cdb_rob_idx), 32'(e_rob));
      chk($sformatf("v%0d_data", v), cdb_data, e_data);
      chk($sformatf("v%0d_we", v), 32'(cdb_regf_we), 32'(e_we));
      chk($sformatf("v%0d_ptr", v), 32'(dut.rr_ptr), 32'(tbl[v].exp_ptr));
    end

`ifdef CDB_PERF_EN
    begin
      logic [3:0] pending;
      logic [3:0] rdy;
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; req_valid = '0; req_regf_we = 4'b1111;
      set_payload(0, 1'b0);
      @(posedge clk);
      pending = 4'b1111;
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        rst = 1'b0; req_valid = pending;
        #1 rdy = req_ready;
        @(posedge clk);
        pending = pending & ~rdy;
      end
      #1;
      chk("perf_bcast", perf_bcast_cnt, 32'd4);
      chk("perf_stall0", perf_stall_cnt[CDB_REQ_BR*32 +: 32], 32'd0);
      chk("perf_stall1", perf_stall_cnt[CDB_REQ_ALU*32 +: 32], 32'd1);
      chk("perf_stall2", perf_stall_cnt[CDB_REQ_MUL*32 +: 32], 32'd2);
      chk("perf_stall3", perf_stall_cnt[CDB_REQ_LSU*32 +: 32], 32'd3);

      // Reset in the middle of traffic
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        req_valid = 4'b1111;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("perf_rst_valid", 32'(cdb_valid), 32'h0);
      chk("perf_rst_bcast", perf_bcast_cnt, 32'd0);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("perf_rst_stall%0d", i), perf_stall_cnt[i*32 +: 32], 32'd0);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
